// File: rtl/ntt_addr_gen.sv
// NTT butterfly address sequencer: emits (addr_a, addr_b, tw_idx) beats for forward/inverse transforms.
// Optional inter-stage drain barrier is compiled in with NTT_ADDR_GEN_STAGE_BARRIER_EN.
module ntt_addr_gen #(
  parameter int LOG_N          = 8,
  parameter int NUM_STAGES     = 7,
  parameter int LANES          = 1,
  parameter int BARRIER_CYCLES = 2,
  localparam int SW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   inverse,
  output logic                   busy,
  output logic                   done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*LOG_N-1:0] addr_a,
  output logic [LANES*LOG_N-1:0] addr_b,
  output logic [LOG_N-2:0]       tw_idx,
  output logic [SW-1:0]          stage,
  output logic                   stage_last
);

  localparam int unsigned N = 1 << LOG_N;
  localparam int unsigned W = LOG_N + 1;

  localparam logic [W-1:0]       N_W        = W'(N);
  localparam logic [W-1:0]       LANES_W    = W'(LANES);
  localparam logic [W-1:0]       LEN_FWD0   = W'(N / 2);
  localparam logic [W-1:0]       LEN_INV0   = W'(1 << (LOG_N - NUM_STAGES));
  localparam logic [LOG_N-2:0]   K_FWD0     = (LOG_N-1)'(1);
  localparam logic [LOG_N-2:0]   K_INV0     = (LOG_N-1)'((1 << NUM_STAGES) - 1);
  localparam logic [SW-1:0]      LAST_STAGE = SW'(NUM_STAGES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
`ifdef NTT_ADDR_GEN_STAGE_BARRIER_EN
  localparam logic [1:0] S_BARRIER = 2'd2;
  logic [31:0] bar_cnt;
`endif

  logic [1:0]       state;
  logic             inv_r;
  logic [W-1:0]     len_r;
  logic [W-1:0]     base_r;
  logic [W-1:0]     off_r;
  logic [LOG_N-2:0] k_r;
  logic [SW-1:0]    stage_r;
  logic             done_r;

  logic run;
  logic grp_end;
  logic stg_end;

  // Group/stage boundaries are decoded from the counters so they align with the beat on the outputs.
  assign run     = (state == S_RUN);
  assign grp_end = ((off_r + LANES_W) == len_r);
  assign stg_end = grp_end && ((base_r + (len_r << 1)) == N_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      inv_r   <= 1'b0;
      len_r   <= '0;
      base_r  <= '0;
      off_r   <= '0;
      k_r     <= '0;
      stage_r <= '0;
      done_r  <= 1'b0;
`ifdef NTT_ADDR_GEN_STAGE_BARRIER_EN
      bar_cnt <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            inv_r   <= inverse;
            stage_r <= '0;
            base_r  <= '0;
            off_r   <= '0;
            len_r   <= inverse ? LEN_INV0 : LEN_FWD0;
            k_r     <= inverse ? K_INV0 : K_FWD0;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            if (grp_end) begin
              off_r <= '0;
              k_r   <= inv_r ? (k_r - 1'b1) : (k_r + 1'b1);
              if (stg_end) begin
                base_r <= '0;
                if (stage_r == LAST_STAGE) begin
                  state  <= S_IDLE;
                  done_r <= 1'b1;
                end else begin
                  stage_r <= stage_r + 1'b1;
                  len_r   <= inv_r ? (len_r << 1) : (len_r >> 1);
`ifdef NTT_ADDR_GEN_STAGE_BARRIER_EN
                  if (BARRIER_CYCLES > 0) begin
                    state   <= S_BARRIER;
                    bar_cnt <= 32'(BARRIER_CYCLES - 1);
                  end
`endif
                end
              end else begin
                base_r <= base_r + (len_r << 1);
              end
            end else begin
              off_r <= off_r + LANES_W;
            end
          end
        end
`ifdef NTT_ADDR_GEN_STAGE_BARRIER_EN
        S_BARRIER: begin
          if (bar_cnt == '0) state <= S_RUN;
          else               bar_cnt <= bar_cnt - 1'b1;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are zero outside RUN so reset, idle and barrier all present a quiet bus.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = done_r;
    out_valid  = run;
    addr_a     = '0;
    addr_b     = '0;
    tw_idx     = '0;
    stage      = '0;
    stage_last = 1'b0;
    if (run) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        addr_a[i*LOG_N +: LOG_N] = LOG_N'(base_r + off_r + W'(i));
        addr_b[i*LOG_N +: LOG_N] = LOG_N'(base_r + off_r + W'(i) + len_r);
      end
      tw_idx     = k_r;
      stage      = stage_r;
      stage_last = stg_end;
    end
  end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Randomized self-checking bench for ntt_addr_gen against a loop-nest reference of the butterfly schedule.
module tb_ntt_addr_gen;

  localparam int LOG_N = 8;
  localparam int NS    = 7;
  localparam int LANES = 1;
  localparam int BCYC  = 2;
  localparam int N     = 1 << LOG_N;
  localparam int AW    = LANES * LOG_N;
  localparam int SW    = (NS > 1) ? $clog2(NS) : 1;
  localparam int NB    = NS * N / (2 * LANES);
`ifdef NTT_ADDR_GEN_STAGE_BARRIER_EN
  localparam int BAR = BCYC;
`else
  localparam int BAR = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          inverse;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [LOG_N-2:0] tw_idx;
  logic [SW-1:0] stage;
  logic          stage_last;

  ntt_addr_gen #(
    .LOG_N(LOG_N),
    .NUM_STAGES(NS),
    .LANES(LANES),
    .BARRIER_CYCLES(BCYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .inverse(inverse),
    .busy(busy),
    .done(done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .tw_idx(tw_idx),
    .stage(stage),
    .stage_last(stage_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint a;
    longint b;
    int     tw;
    int     stg;
    bit     last;
  } beat_t;

  beat_t exp_q[$];

  function automatic void build(input bit inv);
    int k;
    int len;
    exp_q.delete();
    k = inv ? (1 << NS) - 1 : 1;
    for (int s = 0; s < NS; s++) begin
      len = inv ? ((1 << (LOG_N - NS)) << s) : ((N / 2) >> s);
      for (int base = 0; base < N; base += 2 * len) begin
        for (int j = base; j < base + len; j += LANES) begin
          beat_t bt;
          bt.a = 0;
          bt.b = 0;
          for (int i = 0; i < LANES; i++) begin
            bt.a |= longint'(j + i) << (i * LOG_N);
            bt.b |= longint'(j + i + len) << (i * LOG_N);
          end
          bt.tw   = k;
          bt.stg  = s;
          bt.last = (base + 2 * len == N) && (j + LANES == base + len);
          exp_q.push_back(bt);
        end
        k = inv ? k - 1 : k + 1;
      end
    end
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_valid"},  out_valid, 0);
    check({tag, "_a"},      addr_a, 0);
    check({tag, "_b"},      addr_b, 0);
    check({tag, "_tw"},     tw_idx, 0);
    check({tag, "_stage"},  stage, 0);
    check({tag, "_slast"},  stage_last, 0);
  endtask

  // Called at a negedge; issues start there and tracks the transform beat by beat.
  task automatic run_xform(input bit inv, input bit rand_rdy, input int abort_at);
    int idx;
    int busy_cyc;
    int bar_left;
    int hold;
    bit dropped;
    bit fin;
    bit ended;
    build(inv);
    start    = 1'b1;
    inverse  = inv;
    idx      = 0;
    busy_cyc = 0;
    bar_left = 0;
    hold     = 0;
    dropped  = 0;
    fin      = 0;
    ended    = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      start   = rand_rdy && (idx == 200);
      inverse = 1'($urandom);
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        repeat (2) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        return;
      end
      if (fin) begin
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("valid_end", out_valid, 0);
        ended = 1;
        break;
      end
      check("done_early", done, 0);
      check("busy", busy, 1);
      if (busy) busy_cyc++;
      check("valid", out_valid, (bar_left == 0));
      if (bar_left > 0) bar_left--;
      if (out_valid && idx < NB) begin
        check("addr_a", addr_a, exp_q[idx].a);
        check("addr_b", addr_b, exp_q[idx].b);
        check("tw_idx", tw_idx, exp_q[idx].tw);
        check("stage", stage, exp_q[idx].stg);
        check("stage_last", stage_last, exp_q[idx].last);
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else if (rand_rdy && idx == 300 && !dropped) begin
        out_ready = 1'b0;
        hold      = 4;
        dropped   = 1;
      end else begin
        out_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (out_valid && out_ready && idx < NB) begin
        if (exp_q[idx].last && exp_q[idx].stg < NS - 1) bar_left = BAR;
        if (idx == NB - 1) fin = 1;
        idx++;
      end
    end
    if (!ended) check("timeout", 0, 1);
    check("accepted", idx, NB);
    if (!rand_rdy) check("busy_cycles", busy_cyc, NB + (NS - 1) * BAR);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    inverse   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    run_xform(1'b0, 1'b0, -1);
    run_xform(1'b1, 1'b0, -1);
    run_xform(1'b0, 1'b1, -1);
    run_xform(1'b1, 1'b1, -1);
    run_xform(1'b0, 1'b0, 400);
    check_quiet("post_abort");
    run_xform(1'b0, 1'b0, -1);
    @(negedge clk);
    check_quiet("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
